// File: rtl/spi_deserializer.sv
// SPI receive deserializer: oversamples sclk/mosi on clk, assembles MSB-first frames
// and hands each completed frame to a FIFO through a one-cycle write strobe.
module spi_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  full,
  input  logic                  overflow_clr,
  output logic                  write_en,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  busy,
  output logic                  overflow,
  output logic                  frame_error
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  sclk_s1_q, sclk_s1_d, sclk_s2_q, sclk_s2_d, sclk_prev_q, sclk_prev_d;
  logic                  mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  write_en_q, write_en_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  overflow_q, overflow_d;
  logic                  frame_error_q, frame_error_d;

  logic                  rise;
  logic                  overflow_set;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] first_bit;

  always_comb begin
    sclk_s1_d     = sclk;
    sclk_s2_d     = sclk_s1_q;
    sclk_prev_d   = sclk_s2_q;
    mosi_s1_d     = mosi;
    mosi_s2_d     = mosi_s1_q;

    rise          = sclk_s2_q & ~sclk_prev_q;
    shifted       = {shift_q[DATA_WIDTH-2:0], mosi_s2_q};
    first_bit     = {{(DATA_WIDTH-1){1'b0}}, mosi_s2_q};

    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_d         = tmo_q;
    write_en_d    = 1'b0;
    write_data_d  = write_data_q;
    frame_error_d = 1'b0;
    overflow_set  = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (rise) begin
          shift_d   = first_bit;
          bit_cnt_d = CNT_W'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          shift_d = shifted;
          tmo_d   = '0;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            // Strobe and data are registered so they line up with the STORE cycle.
            state_d      = STORE;
            bit_cnt_d    = '0;
            write_en_d   = ~full;
            write_data_d = shifted;
            overflow_set = full;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d       = IDLE;
          shift_d       = '0;
          bit_cnt_d     = '0;
          tmo_d         = '0;
          frame_error_d = 1'b1;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      STORE: begin
        tmo_d = '0;
        if (rise) begin
          shift_d   = first_bit;
          bit_cnt_d = CNT_W'(1);
          state_d   = SHIFT;
        end else begin
          shift_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        shift_d   = '0;
        bit_cnt_d = '0;
        tmo_d     = '0;
      end
    endcase

    // A new drop outranks a simultaneous clear so the event is never lost.
    if (overflow_set)      overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sclk_s1_q     <= 1'b0;
      sclk_s2_q     <= 1'b0;
      sclk_prev_q   <= 1'b0;
      mosi_s1_q     <= 1'b0;
      mosi_s2_q     <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      tmo_q         <= '0;
      write_en_q    <= 1'b0;
      write_data_q  <= '0;
      overflow_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_s1_q     <= sclk_s1_d;
      sclk_s2_q     <= sclk_s2_d;
      sclk_prev_q   <= sclk_prev_d;
      mosi_s1_q     <= mosi_s1_d;
      mosi_s2_q     <= mosi_s2_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_q         <= tmo_d;
      write_en_q    <= write_en_d;
      write_data_q  <= write_data_d;
      overflow_q    <= overflow_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign write_en    = write_en_q;
  assign write_data  = write_data_q;
  assign busy        = (state_q != IDLE);
  assign overflow    = overflow_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_deserializer.sv
// Directed bench for spi_deserializer: a frame-level model predicts every output
// each cycle; literal per-scenario expectations pin the model.
module tb_spi_deserializer;

  localparam int W   = 8;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         mosi;
  logic         full;
  logic         overflow_clr;
  logic         write_en;
  logic [W-1:0] write_data;
  logic         busy;
  logic         overflow;
  logic         frame_error;

  spi_deserializer #(.DATA_WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .full(full),
    .overflow_clr(overflow_clr), .write_en(write_en), .write_data(write_data),
    .busy(busy), .overflow(overflow), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct { int at; logic b; } rise_t;
  rise_t evq[$];

  logic [W-1:0] got[$];
  int           fe_cnt = 0;

  // Frame-level model state: bits gathered so far and when the last one arrived.
  int           m_cnt = 0;
  int           m_last = 0;
  logic [W-1:0] m_val = '0;
  logic [W-1:0] m_data = '0;
  logic         m_store = 1'b0;
  logic         m_we = 1'b0;
  logic         m_fe = 1'b0;
  logic         m_ovf = 1'b0;
  logic         m_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    logic rise_now;
    logic rb;
    logic set;
    cyc++;
    rise_now = 1'b0;
    rb       = 1'b0;
    set      = 1'b0;
    if (rst) begin
      m_cnt = 0; m_val = '0; m_store = 1'b0; m_we = 1'b0; m_fe = 1'b0;
      m_ovf = 1'b0; m_busy = 1'b0;
      evq.delete();
    end else begin
      if (evq.size() > 0 && evq[0].at == cyc) begin
        rise_now = 1'b1;
        rb       = evq[0].b;
        void'(evq.pop_front());
      end
      m_we = 1'b0;
      m_fe = 1'b0;
      if (rise_now) begin
        m_val  = {m_val[W-2:0], rb};
        m_cnt  = m_cnt + 1;
        m_last = cyc;
        if (m_cnt == W) begin
          m_we    = ~full;
          set     = full;
          m_data  = m_val;
          m_store = 1'b1;
          m_cnt   = 0;
          m_val   = '0;
        end else begin
          m_store = 1'b0;
        end
      end else begin
        m_store = 1'b0;
        if (m_cnt > 0 && (cyc - m_last) == TMO) begin
          m_fe  = 1'b1;
          m_cnt = 0;
          m_val = '0;
        end
      end
      if (set)               m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_busy = (m_cnt > 0) || m_store;
    end
    #1;
    chk("write_en", 32'(write_en), 32'(m_we));
    chk("frame_error", 32'(frame_error), 32'(m_fe));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("busy", 32'(busy), 32'(m_busy));
    if (m_we || rst) chk("write_data", 32'(write_data), 32'(m_we ? m_data : '0));
    if (write_en) got.push_back(write_data);
    if (frame_error) fe_cnt++;
  end

  // Called on a negedge; returns on a negedge one sclk period later.
  task automatic send_bit(input logic b, input int hp, input logic clr_last);
    sclk = 1'b1;
    mosi = b;
    evq.push_back('{cyc + 3, b});
    repeat (hp) @(negedge clk);
    sclk         = 1'b0;
    overflow_clr = clr_last;
    @(negedge clk);
    overflow_clr = 1'b0;
    repeat (hp - 1) @(negedge clk);
  endtask

  task automatic send_byte(input logic [W-1:0] v, input int hp, input logic clr_last);
    for (int i = W - 1; i >= 0; i--) send_bit(v[i], hp, clr_last && (i == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; full = 1'b0; overflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_write_en", 32'(write_en), 32'h0);
    chk("reset_write_data", 32'(write_data), 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 0xA5, full=0
    send_byte(8'hA5, 2, 1'b0);
    repeat (10) @(negedge clk);
    chk("a5_count", 32'(got.size()), 32'd1);
    chk("a5_data", 32'(got[0]), 32'hA5);
    chk("a5_busy", 32'(busy), 32'h0);

    // 0x3C dropped on full, overflow held then cleared
    full = 1'b1;
    send_byte(8'h3C, 2, 1'b0);
    repeat (20) @(negedge clk);
    full = 1'b0;
    chk("ovf_no_write", 32'(got.size()), 32'd1);
    chk("ovf_held", 32'(overflow), 32'h1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'h0);

    // 3 bits then silence, then a clean frame
    send_bit(1'b1, 2, 1'b0);
    send_bit(1'b0, 2, 1'b0);
    send_bit(1'b1, 2, 1'b0);
    repeat (75) @(negedge clk);
    chk("tmo_fe_count", 32'(fe_cnt), 32'd1);
    chk("tmo_no_write", 32'(got.size()), 32'd1);
    chk("tmo_busy", 32'(busy), 32'h0);
    send_byte(8'h3C, 2, 1'b0);
    repeat (6) @(negedge clk);
    chk("tmo_next_data", 32'(got[got.size()-1]), 32'h3C);

    // back-to-back frames
    n = got.size();
    send_byte(8'h01, 2, 1'b0);
    send_byte(8'hFF, 2, 1'b0);
    repeat (6) @(negedge clk);
    chk("b2b_count", 32'(got.size() - n), 32'd2);
    chk("b2b_first", 32'(got[n]), 32'h01);
    chk("b2b_second", 32'(got[n+1]), 32'hFF);
    chk("b2b_no_fe", 32'(fe_cnt), 32'd1);

    // reset mid-frame
    n = got.size();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h5A, 2, 1'b0);
    repeat (6) @(negedge clk);
    chk("rst_count", 32'(got.size() - n), 32'd1);
    chk("rst_data", 32'(got[n]), 32'h5A);
    chk("rst_no_fe", 32'(fe_cnt), 32'd1);

    // set and clear colliding while overflow is already set
    full = 1'b1;
    send_byte(8'h3C, 2, 1'b0);
    repeat (4) @(negedge clk);
    chk("coll_pre", 32'(overflow), 32'h1);
    send_byte(8'hC3, 2, 1'b1);
    repeat (4) @(negedge clk);
    chk("coll_post", 32'(overflow), 32'h1);
    full = 1'b0;

    // fastest usable sclk (period 2 clk)
    n = got.size();
    send_byte(8'h96, 1, 1'b0);
    repeat (6) @(negedge clk);
    chk("fast_count", 32'(got.size() - n), 32'd1);
    chk("fast_data", 32'(got[n]), 32'h96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_deserializer.md
SPI_DESERIALIZER -- requirements
Module: spi_deserializer

Parameters
REQ-001 DATA_WIDTH, default 8: frame and write_data width in bits.
REQ-002 TIMEOUT_CYCLES, default 64: number of clk cycles without a detected sclk rise, while in SHIFT, that aborts a partial frame.

Interface
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset: asynchronous, active-high.
REQ-005 sclk  input  1  serial clock from the SPI transmitter.
REQ-006 mosi  input  1  serial data; MSB first; stable at sclk rise.
REQ-007 full  input  1  receive FIFO full flag.
REQ-008 overflow_clr  input  1  one-cycle pulse that clears overflow.
REQ-009 write_en  output  1  FIFO write strobe; one-cycle pulse.
REQ-010 write_data  output  DATA_WIDTH  assembled frame, valid while write_en=1.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 overflow  output  1  sticky flag: a complete frame was dropped because full=1.
REQ-013 frame_error  output  1  one-cycle pulse: a partial frame was aborted by timeout.

Function
REQ-014 sclk and mosi SHALL each pass through a 2-flop synchronizer; mosi uses the same depth as sclk, so the two stay aligned.
REQ-015 A rise SHALL be detected when synchronized sclk=1 and its previous registered value=0; exactly one rise per sclk low-to-high transition.
REQ-016 On each rise, the synchronized mosi SHALL be shifted into the shift register LSB, existing bits moving left.
  - Net effect: the first bit received ends up in write_data MSB.
REQ-017 The bit counter SHALL be clog2(DATA_WIDTH)+1 bits wide, increment on each rise, and clear on entry to IDLE or STORE.
REQ-018 States: IDLE, SHIFT, STORE.
REQ-019 IDLE: a rise SHALL capture bit 1 and move to SHIFT; otherwise stay in IDLE.
REQ-020 SHIFT: when the rise that captures bit DATA_WIDTH occurs, the state SHALL go to STORE.
REQ-021 SHIFT: if the timeout counter reaches TIMEOUT_CYCLES-1 with no rise, the state SHALL go to IDLE, discard the partial frame, and pulse frame_error for one cycle.
REQ-022 The timeout counter SHALL clear on every rise and on entering SHIFT, and SHALL saturate rather than wrap.
REQ-023 STORE lasts exactly one cycle; write_en=!full and write_data=the shift register, both registered, during that cycle.
  - write_en is asserted exactly 1 clk after the cycle in which the final rise is detected.
REQ-024 STORE with full=1: write_en SHALL stay 0 and overflow SHALL be set to 1.
REQ-025 Rise detected in the STORE cycle: it SHALL be captured as bit 1 of the next frame and the state goes to SHIFT; otherwise the state goes to IDLE.
REQ-026 overflow SHALL hold until overflow_clr=1.
  - If a set and overflow_clr occur in the same cycle, the set wins and overflow stays 1.
REQ-027 write_en SHALL never be high for two consecutive cycles, and SHALL never be high outside STORE.
REQ-028 frame_error and write_en SHALL never be high in the same cycle.

Reset
REQ-029 rst=1 SHALL immediately force the following, regardless of clk:
  - state=IDLE; shift register, bit counter, timeout counter, synchronizers = 0;
  - write_en=0, write_data=0, busy=0, overflow=0, frame_error=0.
REQ-030 rst asserted mid-frame SHALL discard the partial frame with no write_en and no frame_error; the first rise after release starts a fresh frame.

Verification
REQ-031 0xA5 sent MSB first with sclk period 4 clk, full=0 -> exactly one write_en pulse with write_data=0xA5, busy low afterwards.
REQ-032 0x3C sent with full=1 at STORE -> no write_en and overflow=1 held 20 cycles; then overflow_clr pulse -> overflow=0 next cycle.
REQ-033 3 bits sent, then sclk idle 64 cycles -> frame_error one-cycle pulse, state IDLE, no write_en; a following frame 0x3C -> write_data=0x3C.
REQ-034 Back-to-back frames 0x01 then 0xFF with no gap -> two write_en pulses, data 0x01 then 0xFF, no frame_error.
REQ-035 rst pulsed after 4 bits of 0xFF, then full frame 0x5A -> all outputs 0 during reset; one write with write_data=0x5A.
REQ-036 overflow already 1, full=1 at STORE and overflow_clr=1 in the same cycle -> overflow remains 1.
